registrador_flags_nzcv: RTL and testbench

- Architectural NZCV status register that feeds FlagsNZCV to the condition-validation stage directly downstream.
- Captures ALU/shifter flags for flag-setting instructions that were not inhibited.
- Accepts direct MSR-style writes.
- Holds one saved copy (SPSR) for exception entry/return, using a two-state exception FSM.

---
 rtl/registrador_flags_nzcv_pkg.sv | 17 +
 rtl/registrador_flags_nzcv_if.sv | 38 +++
 rtl/registrador_flags_nzcv_calc_prox_nzcv.sv | 41 ++++
 rtl/registrador_flags_nzcv.sv | 98 +++++++++
 tb/tb_registrador_flags_nzcv.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/registrador_flags_nzcv_pkg.sv
// Shared types for the NZCV flag register slice.
// Flag bit positions, the 4-bit flag vector and the exception FSM states.
package pacote_arm;

  localparam int IDX_N = 3;
  localparam int IDX_Z = 2;
  localparam int IDX_C = 1;
  localparam int IDX_V = 0;

  typedef logic [3:0] nzcv_t;

  typedef enum logic {
    NORM = 1'b0,
    EXC  = 1'b1
  } estado_t;

endpackage

// File: rtl/registrador_flags_nzcv_if.sv
// Flag register bus: ALU/shifter flags, MSR write and exception events in,
// current flags, saved flags, exception state and error pulse out.
interface registrador_flags_nzcv_if;
  import pacote_arm::*;

  logic  AluValid;
  logic  SetFlags;
  logic  Inibe;
  logic  LogicOp;
  logic  AluN;
  logic  AluZ;
  logic  AluC;
  logic  AluV;
  logic  ShiftC;
  logic  MsrWrite;
  nzcv_t MsrData;
  logic  ExcEntry;
  logic  ExcReturn;
  nzcv_t FlagsNZCV;
  nzcv_t Spsr;
  logic  EmExcecao;
  logic  Erro;

  modport master (
    output AluValid, SetFlags, Inibe, LogicOp,
    output AluN, AluZ, AluC, AluV, ShiftC,
    output MsrWrite, MsrData, ExcEntry, ExcReturn,
    input  FlagsNZCV, Spsr, EmExcecao, Erro
  );

  modport slave (
    input  AluValid, SetFlags, Inibe, LogicOp,
    input  AluN, AluZ, AluC, AluV, ShiftC,
    input  MsrWrite, MsrData, ExcEntry, ExcReturn,
    output FlagsNZCV, Spsr, EmExcecao, Erro
  );

endinterface

// File: rtl/registrador_flags_nzcv_calc_prox_nzcv.sv
// Combinational next-NZCV from MSR write, ALU update or hold.
// Ports: current flags and ALU/shifter/MSR inputs in, candidate flags out.
module calc_prox_nzcv
  import pacote_arm::*;
(
  input  nzcv_t atual,
  input  logic  alu_valid,
  input  logic  set_flags,
  input  logic  inibe,
  input  logic  logic_op,
  input  logic  alu_n,
  input  logic  alu_z,
  input  logic  alu_c,
  input  logic  alu_v,
  input  logic  shift_c,
  input  logic  msr_write,
  input  nzcv_t msr_data,
  output nzcv_t proximo
);

  logic alu_upd;

  assign alu_upd = alu_valid & set_flags & ~inibe;

  always_comb begin
    proximo = atual;
    if (msr_write) begin
      proximo = msr_data;
    end else if (alu_upd) begin
      proximo[IDX_N] = alu_n;
      proximo[IDX_Z] = alu_z;
      if (logic_op) begin
        proximo[IDX_C] = shift_c;
      end else begin
        proximo[IDX_C] = alu_c;
        proximo[IDX_V] = alu_v;
      end
    end
  end

endmodule

// File: rtl/registrador_flags_nzcv.sv
// Architectural NZCV register with one SPSR copy and exception FSM.
// Ports: Clock, Reset (sync, active-high), bus (slave). Macro FLAGS_BYPASS_EN.
module registrador_flags_nzcv
  import pacote_arm::*;
#(
  parameter nzcv_t RESET_NZCV = 4'b0000,
  parameter nzcv_t RESET_SPSR = 4'b0000
) (
  input logic                    Clock,
  input logic                    Reset,
  registrador_flags_nzcv_if.slave bus
);

  nzcv_t   nzcv_q, nzcv_d, calc_nzcv;
  nzcv_t   spsr_q, spsr_d;
  estado_t estado_q, estado_d;
  logic    erro_q, erro_d;
  logic    ambos, entrada, retorno;
  logic    ret_legal;

  // Simultaneous entry and return cancel each other and count as illegal.
  assign ambos   = bus.ExcEntry & bus.ExcReturn;
  assign entrada = bus.ExcEntry & ~bus.ExcReturn;
  assign retorno = bus.ExcReturn & ~bus.ExcEntry;

  calc_prox_nzcv u_calc (
    .atual     (nzcv_q),
    .alu_valid (bus.AluValid),
    .set_flags (bus.SetFlags),
    .inibe     (bus.Inibe),
    .logic_op  (bus.LogicOp),
    .alu_n     (bus.AluN),
    .alu_z     (bus.AluZ),
    .alu_c     (bus.AluC),
    .alu_v     (bus.AluV),
    .shift_c   (bus.ShiftC),
    .msr_write (bus.MsrWrite),
    .msr_data  (bus.MsrData),
    .proximo   (calc_nzcv)
  );

  always_comb begin
    estado_d  = estado_q;
    spsr_d    = spsr_q;
    erro_d    = ambos;
    ret_legal = 1'b0;
    unique case (estado_q)
      NORM: begin
        if (entrada) begin
          estado_d = EXC;
          spsr_d   = nzcv_q;
        end else if (retorno) begin
          erro_d = 1'b1;
        end
      end
      EXC: begin
        if (retorno) begin
          estado_d  = NORM;
          ret_legal = 1'b1;
        end else if (entrada) begin
          erro_d = 1'b1;
        end
      end
      default: begin
        estado_d = NORM;
      end
    endcase
  end

  assign nzcv_d = ret_legal ? spsr_q : calc_nzcv;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      nzcv_q   <= RESET_NZCV;
      spsr_q   <= RESET_SPSR;
      estado_q <= NORM;
      erro_q   <= 1'b0;
    end else begin
      nzcv_q   <= nzcv_d;
      spsr_q   <= spsr_d;
      estado_q <= estado_d;
      erro_q   <= erro_d;
    end
  end

`ifdef FLAGS_BYPASS_EN
  // Forward MSR/ALU results; the SPSR restore stays registered so the
  // Inibe path through the validation stage does not form a loop.
  assign bus.FlagsNZCV = calc_nzcv;
`else
  assign bus.FlagsNZCV = nzcv_q;
`endif

  assign bus.Spsr      = spsr_q;
  assign bus.EmExcecao = (estado_q == EXC);
  assign bus.Erro      = erro_q;

endmodule

// File: tb/tb_registrador_flags_nzcv.sv
// Directed + random checks of registrador_flags_nzcv against a flag model.
// Drives the bus master modport; compares all outputs after each edge.
module tb_registrador_flags_nzcv;

  localparam logic [3:0] RN = 4'b0101;
  localparam logic [3:0] RS = 4'b0000;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  registrador_flags_nzcv_if bus ();

  registrador_flags_nzcv #(
    .RESET_NZCV (RN),
    .RESET_SPSR (RS)
  ) dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  logic [3:0] m_nzcv, m_spsr;
  logic       m_exc, m_erro;

  task automatic idle();
    rst = 1'b0;
    bus.AluValid = 0; bus.SetFlags = 0; bus.Inibe = 0;
    bus.LogicOp = 0; bus.AluN = 0; bus.AluZ = 0;
    bus.AluC = 0; bus.AluV = 0; bus.ShiftC = 0;
    bus.MsrWrite = 0; bus.MsrData = 4'b0000;
    bus.ExcEntry = 0; bus.ExcReturn = 0;
  endtask

  task automatic check4(string tag, logic [3:0] got, logic [3:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s got=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic check1(string tag, logic got, logic exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s got=%b expected=%b", tag, got, exp);
    end
  endtask

  // Apply current inputs for one cycle, advance the model, compare.
  task automatic step(string tag);
    logic [3:0] nv;
    logic       upd, ill;
    nv = m_nzcv;
    upd = bus.AluValid && bus.SetFlags && !bus.Inibe;
    if (bus.MsrWrite) nv = bus.MsrData;
    else if (upd) begin
      nv[3] = bus.AluN;
      nv[2] = bus.AluZ;
      nv[1] = bus.LogicOp ? bus.ShiftC : bus.AluC;
      if (!bus.LogicOp) nv[0] = bus.AluV;
    end
`ifdef FLAGS_BYPASS_EN
    #1;
    if (!rst) check4({tag, ".bypass"}, bus.FlagsNZCV, nv);
`endif
    @(posedge clk);
    if (rst) begin
      m_nzcv = RN; m_spsr = RS; m_exc = 0; m_erro = 0;
    end else begin
      ill = 0;
      if (bus.ExcEntry && bus.ExcReturn) ill = 1;
      else if (bus.ExcEntry) begin
        if (m_exc) ill = 1;
        else begin m_spsr = m_nzcv; m_exc = 1; end
      end else if (bus.ExcReturn) begin
        if (!m_exc) ill = 1;
        else begin nv = m_spsr; m_exc = 0; end
      end
      m_nzcv = nv;
      m_erro = ill;
    end
    #1;
    check4({tag, ".nzcv"}, bus.FlagsNZCV, m_nzcv);
    check4({tag, ".spsr"}, bus.Spsr, m_spsr);
    check1({tag, ".exc"}, bus.EmExcecao, m_exc);
    check1({tag, ".erro"}, bus.Erro, m_erro);
  endtask

  task automatic alu(logic lop, logic inb, logic [3:0] f, logic sc);
    bus.AluValid = 1; bus.SetFlags = 1; bus.Inibe = inb;
    bus.LogicOp = lop; bus.AluN = f[3]; bus.AluZ = f[2];
    bus.AluC = f[1]; bus.AluV = f[0]; bus.ShiftC = sc;
  endtask

  task automatic msr(logic [3:0] d);
    bus.MsrWrite = 1; bus.MsrData = d;
  endtask

  initial begin
    m_nzcv = 'x; m_spsr = 'x; m_exc = 'x; m_erro = 'x;
    idle();
    rst = 1;
    step("reset");
    idle();

    // Explicit reset-value checks against literal constants.
    check4("reset.const", bus.FlagsNZCV, 4'b0101);
    check1("reset.erro0", bus.Erro, 1'b0);

    msr(4'b0000); step("clr"); idle();
    alu(0, 0, 4'b1011, 0); step("arith");
    check4("arith.const", bus.FlagsNZCV, 4'b1011);
    alu(0, 1, 4'b0100, 0); step("inhib");
    check4("inhib.const", bus.FlagsNZCV, 4'b1011);
    idle();

    msr(4'b0001); step("set0001"); idle();
    alu(1, 0, 4'b0100, 1); step("logic");
    check4("logic.const", bus.FlagsNZCV, 4'b0111);
    idle();

    msr(4'b1100); alu(0, 0, 4'b0011, 0); step("msr_vs_alu");
    check4("msr.const", bus.FlagsNZCV, 4'b1100);
    idle();

    msr(4'b1010); step("set1010"); idle();
    bus.ExcEntry = 1; step("entry"); idle();
    check4("entry.spsr", bus.Spsr, 4'b1010);
    msr(4'b0000); step("msr_in_exc"); idle();
    bus.ExcReturn = 1; step("return"); idle();
    check4("return.const", bus.FlagsNZCV, 4'b1010);

    bus.ExcReturn = 1; step("ret_norm"); idle();
    check1("ret_norm.erro", bus.Erro, 1'b1);
    step("ret_norm_after");
    check1("ret_norm.pulse", bus.Erro, 1'b0);

    bus.ExcEntry = 1; step("entry1"); idle();
    msr(4'b0110); step("msr2"); idle();
    bus.ExcEntry = 1; step("nest"); idle();
    check4("nest.spsr", bus.Spsr, 4'b1010);
    step("nest_after");

    bus.ExcEntry = 1; bus.ExcReturn = 1; step("both"); idle();
    rst = 1; step("reset_exc"); idle();

    msr(4'b1001); bus.ExcEntry = 1; step("entry_msr"); idle();
    bus.ExcReturn = 1; alu(0, 0, 4'b0110, 0); step("ret_vs_alu"); idle();

    for (int i = 0; i < 300; i++) begin
      rst          = ($urandom_range(0, 39) == 0);
      bus.AluValid = $urandom_range(0, 1);
      bus.SetFlags = $urandom_range(0, 1);
      bus.Inibe    = ($urandom_range(0, 3) == 0);
      bus.LogicOp  = $urandom_range(0, 1);
      bus.AluN     = $urandom_range(0, 1);
      bus.AluZ     = $urandom_range(0, 1);
      bus.AluC     = $urandom_range(0, 1);
      bus.AluV     = $urandom_range(0, 1);
      bus.ShiftC   = $urandom_range(0, 1);
      bus.MsrWrite = ($urandom_range(0, 4) == 0);
      bus.MsrData  = 4'($urandom_range(0, 15));
      bus.ExcEntry  = ($urandom_range(0, 5) == 0);
      bus.ExcReturn = ($urandom_range(0, 5) == 0);
      step("rand");
    end
    idle();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
